// File: rtl/operand_fetch.sv
// Operand fetch stage: takes decoded register indices, reads the 16x32 register
// file, forwards in-flight writebacks and hands rs1/rs2 values plus rd downstream.
module operand_fetch #(
   parameter int XLEN = 32,
   parameter int AW   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1,
   input  logic [AW-1:0]   in_rs2,
   input  logic [AW-1:0]   in_rd,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            rf_enable_n,
   output logic            rf_write_en,
   output logic [AW-1:0]   rf_write_addr,
   output logic [XLEN-1:0] rf_write_data,
   output logic [AW-1:0]   rf_read_addr_a,
   output logic [AW-1:0]   rf_read_addr_b,
   input  logic [XLEN-1:0] rf_read_data_a,
   input  logic [XLEN-1:0] rf_read_data_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [AW-1:0]   out_rd
);

   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic            byp1_q, byp1_d, byp2_q, byp2_d;
   logic [XLEN-1:0] bypData1_q, bypData1_d, bypData2_q, bypData2_d;
   logic            outValid_q, outValid_d;
   logic [XLEN-1:0] outRs1_q, outRs1_d, outRs2_q, outRs2_d;
   logic [AW-1:0]   outRd_q, outRd_d;

   logic            accept;
   logic            match1In, match2In, match1Q, match2Q;
   logic [XLEN-1:0] rs1Val, rs2Val;

   // A writeback hits index x only when it targets a real (non-r0) register.
   function automatic logic wbMatch(input logic v, input logic [AW-1:0] wa,
                                    input logic [AW-1:0] x);
      return v & (wa == x) & (x != '0);
   endfunction

   assign rf_enable_n   = reset;
   assign rf_write_en   = wb_valid & ~reset & (wb_addr != '0);
   assign rf_write_addr = wb_addr;
   assign rf_write_data = wb_data;

   assign out_valid    = outValid_q;
   assign out_rs1_data = outRs1_q;
   assign out_rs2_data = outRs2_q;
   assign out_rd       = outRd_q;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = READ;
         READ:    state_d = HOLD;
         HOLD:    if (out_ready) state_d = in_valid ? READ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake, read addressing and operand selection; the RF returns the
   // pre-write value on a same-cycle collision, hence the bypass latch.
   always_comb begin
      in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
      accept   = in_valid & in_ready;
      match1In = wbMatch(wb_valid, wb_addr, in_rs1);
      match2In = wbMatch(wb_valid, wb_addr, in_rs2);
      match1Q  = wbMatch(wb_valid, wb_addr, rs1_q);
      match2Q  = wbMatch(wb_valid, wb_addr, rs2_q);
      rf_read_addr_a = accept ? in_rs1 : rs1_q;
      rf_read_addr_b = accept ? in_rs2 : rs2_q;
      if (match1Q)            rs1Val = wb_data;
      else if (byp1_q)        rs1Val = bypData1_q;
      else if (rs1_q == '0)   rs1Val = '0;
      else                    rs1Val = rf_read_data_a;
      if (match2Q)            rs2Val = wb_data;
      else if (byp2_q)        rs2Val = bypData2_q;
      else if (rs2_q == '0)   rs2Val = '0;
      else                    rs2Val = rf_read_data_b;
   end

   // Datapath next-state: capture in READ, forward while stalled in HOLD
   always_comb begin
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      byp1_d     = byp1_q;
      byp2_d     = byp2_q;
      bypData1_d = bypData1_q;
      bypData2_d = bypData2_q;
      outValid_d = outValid_q;
      outRs1_d   = outRs1_q;
      outRs2_d   = outRs2_q;
      outRd_d    = outRd_q;
      case (state_q)
         READ: begin
            outRs1_d   = rs1Val;
            outRs2_d   = rs2Val;
            outRd_d    = rd_q;
            outValid_d = 1'b1;
            byp1_d     = 1'b0;
            byp2_d     = 1'b0;
         end
         HOLD: begin
            if (out_ready) begin
               outValid_d = 1'b0;
            end else begin
               if (match1Q) outRs1_d = wb_data;
               if (match2Q) outRs2_d = wb_data;
            end
         end
         default: ;
      endcase
      if (accept) begin
         rs1_d  = in_rs1;
         rs2_d  = in_rs2;
         rd_d   = in_rd;
         byp1_d = match1In;
         byp2_d = match2In;
         if (match1In) bypData1_d = wb_data;
         if (match2In) bypData2_d = wb_data;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         byp1_q     <= 1'b0;
         byp2_q     <= 1'b0;
         bypData1_q <= '0;
         bypData2_q <= '0;
         outValid_q <= 1'b0;
         outRs1_q   <= '0;
         outRs2_q   <= '0;
         outRd_q    <= '0;
      end else begin
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         byp1_q     <= byp1_d;
         byp2_q     <= byp2_d;
         bypData1_q <= bypData1_d;
         bypData2_q <= bypData2_d;
         outValid_q <= outValid_d;
         outRs1_q   <= outRs1_d;
         outRs2_q   <= outRs2_d;
         outRd_q    <= outRd_d;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register-file model plus an architectural-state
// reference that expects presented operands to always equal current register values.
module tb_operand_fetch;
   localparam int XLEN = 32;
   localparam int AW   = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready;
   logic [AW-1:0]   in_rs1, in_rs2, in_rd;
   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            rf_enable_n, rf_write_en;
   logic [AW-1:0]   rf_write_addr, rf_read_addr_a, rf_read_addr_b;
   logic [XLEN-1:0] rf_write_data, rf_read_data_a, rf_read_data_b;
   logic            out_valid, out_ready;
   logic [XLEN-1:0] out_rs1_data, out_rs2_data;
   logic [AW-1:0]   out_rd;

   always #5 clk = ~clk;

   operand_fetch #(.XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_enable_n(rf_enable_n), .rf_write_en(rf_write_en),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
      .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd)
   );

   // Register file: registered reads return the pre-write value, r0 reads zero
   logic [XLEN-1:0] rfMem [16];
   always @(posedge clk) begin
      if (!rf_enable_n && rf_write_en) rfMem[rf_write_addr] <= rf_write_data;
      rf_read_data_a <= (rf_read_addr_a == '0) ? '0 : rfMem[rf_read_addr_a];
      rf_read_data_b <= (rf_read_addr_b == '0) ? '0 : rfMem[rf_read_addr_b];
   end

   logic [XLEN-1:0] arch [16];
   int   checks = 0;
   int   errors = 0;
   bit   expValid, inFlight;
   logic [AW-1:0] pendRs1, pendRs2, pendRd, holdRs1, holdRs2, holdRd, lastRs1, lastRs2;

   function automatic logic [XLEN-1:0] archVal(input logic [AW-1:0] i);
      return (i == '0) ? '0 : arch[i];
   endfunction

   task automatic check32(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check32("out_valid", {31'b0, out_valid}, {31'b0, expValid});
      if (expValid) begin
         check32("out_rs1_data", out_rs1_data, archVal(holdRs1));
         check32("out_rs2_data", out_rs2_data, archVal(holdRs2));
         check32("out_rd", {28'b0, out_rd}, {28'b0, holdRd});
      end
   endtask

   task automatic applyStimulus(input bit iv, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                input logic [AW-1:0] rd, input bit ordy, input bit wv,
                                input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
      bit expReady, acc;
      in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
      out_ready = ordy; wb_valid = wv; wb_addr = wa; wb_data = wd;
      #1;
      expReady = !inFlight && (!expValid || ordy);
      acc      = iv && expReady;
      check32("in_ready", {31'b0, in_ready}, {31'b0, expReady});
      check32("rf_write_en", {31'b0, rf_write_en}, {31'b0, wv && (wa != '0)});
      check32("rf_enable_n", {31'b0, rf_enable_n}, 32'd0);
      if (wv) begin
         check32("rf_write_addr", {28'b0, rf_write_addr}, {28'b0, wa});
         check32("rf_write_data", rf_write_data, wd);
      end
      check32("rf_read_addr_a", {28'b0, rf_read_addr_a}, {28'b0, acc ? r1 : lastRs1});
      check32("rf_read_addr_b", {28'b0, rf_read_addr_b}, {28'b0, acc ? r2 : lastRs2});
      if (wv && wa != '0) arch[wa] = wd;
      if (inFlight) begin
         expValid = 1'b1;
         holdRs1 = pendRs1; holdRs2 = pendRs2; holdRd = pendRd;
         inFlight = 1'b0;
      end else if (expValid && ordy) begin
         expValid = 1'b0;
      end
      if (acc) begin
         inFlight = 1'b1;
         pendRs1 = r1; pendRs2 = r2; pendRd = rd;
         lastRs1 = r1; lastRs2 = r2;
      end
      @(posedge clk); #1;
      checkOutput();
   endtask

   initial begin
      logic [XLEN-1:0] v;
      for (int i = 0; i < 16; i++) arch[i] = '0;
      expValid = 0; inFlight = 0;
      pendRs1 = 0; pendRs2 = 0; pendRd = 0; holdRs1 = 0; holdRs2 = 0; holdRd = 0;
      lastRs1 = 0; lastRs2 = 0;
      reset = 1'b1; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      out_ready = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
      repeat (2) @(posedge clk);
      #1;
      check32("rst_enable_n", {31'b0, rf_enable_n}, 32'd1);
      check32("rst_write_en", {31'b0, rf_write_en}, 32'd0);
      reset = 1'b0;
      #1;
      check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check32("rst_rs1", out_rs1_data, 32'd0);
      check32("rst_rs2", out_rs2_data, 32'd0);
      check32("rst_rd", {28'b0, out_rd}, 32'd0);

      // Preload every register through the writeback port
      for (int i = 1; i < 16; i++) begin
         v = $urandom;
         applyStimulus(0, 0, 0, 0, 0, 1, 4'(i), v);
      end

      $display("[TB] basic read");
      applyStimulus(0, 0, 0, 0, 0, 1, 4'd5, 32'h1234_5678);
      applyStimulus(1, 4'd5, 4'd0, 4'd3, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check32("t1_rs1", out_rs1_data, 32'h1234_5678);
      check32("t1_rs2", out_rs2_data, 32'h0);
      check32("t1_rd", {28'b0, out_rd}, 32'd3);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

      $display("[TB] same-cycle collision");
      applyStimulus(0, 0, 0, 0, 0, 1, 4'd7, 32'h1);
      applyStimulus(1, 4'd7, 4'd0, 4'd1, 0, 1, 4'd7, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check32("t2_rs1", out_rs1_data, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

      $display("[TB] read-cycle forward");
      applyStimulus(1, 4'd1, 4'd9, 4'd2, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 4'd9, 32'hCAFE_0000);
      check32("t3_rs2", out_rs2_data, 32'hCAFE_0000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 4'd9, 4'd0, 4'd2, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check32("t3_rf_r9", out_rs1_data, 32'hCAFE_0000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

      $display("[TB] backpressure");
      applyStimulus(1, 4'd4, 4'd4, 4'd6, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 4'd4, 32'h55);
      check32("t4_rs1", out_rs1_data, 32'h55);
      check32("t4_rs2", out_rs2_data, 32'h55);
      check32("t4_rd", {28'b0, out_rd}, 32'd6);
      applyStimulus(1, 4'd2, 4'd4, 4'd8, 1, 0, 0, 0);
      check32("t4_drop", {31'b0, out_valid}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check32("t4_new_rd", {28'b0, out_rd}, 32'd8);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

      $display("[TB] r0 protection");
      applyStimulus(1, 4'd0, 4'd3, 4'd5, 0, 1, 4'd0, 32'hFFFF_FFFF);
      applyStimulus(0, 0, 0, 0, 0, 1, 4'd0, 32'hFFFF_FFFF);
      check32("t5_rs1", out_rs1_data, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] async reset in HOLD");
      reset = 1'b1;
      #1;
      check32("t6_out_valid", {31'b0, out_valid}, 32'd0);
      check32("t6_rs1", out_rs1_data, 32'd0);
      check32("t6_enable_n", {31'b0, rf_enable_n}, 32'd1);
      expValid = 0; inFlight = 0; lastRs1 = 0; lastRs2 = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 4'd3, 4'd5, 4'd7, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         v = $urandom;
         applyStimulus(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
                       4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
                       bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                       4'($urandom_range(0, 5)), v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
